// File: rtl/sprite_motion_ctrl_pkg.sv
// Shared definitions for the sprite motion block: coordinate widths,
// default 640x480 geometry and the per-frame update state machine encoding.
package sprite_motion_ctrl_pkg;

   localparam int unsigned COORD_W = 11;   // coordinate width shared with sync gen / renderer
   localparam int unsigned CALC_W  = 12;   // bounce arithmetic width (one bit of headroom)
   localparam int unsigned SPD_W   = 4;

   localparam int unsigned H_ACTIVE_DEF = 640;
   localparam int unsigned V_ACTIVE_DEF = 480;
   localparam int unsigned SPRITE_W_DEF = 16;
   localparam int unsigned SPRITE_H_DEF = 16;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LATCH  = 3'd1,
      ST_STEP_X = 3'd2,
      ST_STEP_Y = 3'd3,
      ST_DONE   = 3'd4
   } state_e;

   // Leading edge of vsync given the previous and current level and pulse polarity.
   function automatic logic vs_leading(input logic prev, input logic cur, input logic act_low);
      return act_low ? (prev & ~cur) : (~prev & cur);
   endfunction

endpackage

// File: rtl/sprite_axis_step.sv
// One-axis position step with edge bounce. Purely combinational; used once
// for X and once for Y.
module sprite_axis_step
   import sprite_motion_ctrl_pkg::*;
(
   input  logic [COORD_W-1:0] pos,
   input  logic               dir,
   input  logic [SPD_W-1:0]   spd,
   input  logic [COORD_W-1:0] max,
   output logic [COORD_W-1:0] new_pos,
   output logic               new_dir
);

   logic [CALC_W-1:0] p, s, m, nx, over, under;

   // Advance by spd; reflect off max (moving +) or off zero (moving -).
   always_comb begin
      p       = CALC_W'(pos);
      s       = CALC_W'(spd);
      m       = CALC_W'(max);
      nx      = dir ? (p - s) : (p + s);
      over    = nx - m;
      under   = s - p;
      new_pos = nx[COORD_W-1:0];
      new_dir = dir;
      if (!dir && (nx > m)) begin
         new_dir = 1'b1;
         new_pos = (over > m) ? '0 : COORD_W'(m - over);
      end else if (dir && (p < s)) begin
         new_dir = 1'b0;
         new_pos = (under > m) ? max : COORD_W'(under);
      end
   end

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Sprite position owner: once per frame, on the vsync leading edge, latches
// the speed, applies pending collision reversals, steps X then Y with edge
// bounce, and pulses frame_tick when done.
module sprite_motion_ctrl
   import sprite_motion_ctrl_pkg::*;
#(
   parameter int unsigned H_ACTIVE      = H_ACTIVE_DEF,
   parameter int unsigned V_ACTIVE      = V_ACTIVE_DEF,
   parameter int unsigned SPRITE_W      = SPRITE_W_DEF,
   parameter int unsigned SPRITE_H      = SPRITE_H_DEF,
   parameter int unsigned X_INIT        = 128,
   parameter int unsigned Y_INIT        = 128,
   parameter bit          VSYNC_ACT_LOW = 1'b1
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               vsync,
   input  logic               enable,
   input  logic [SPD_W-1:0]   speed,
   input  logic               hit_x,
   input  logic               hit_y,
   output logic [COORD_W-1:0] sprite_x,
   output logic [COORD_W-1:0] sprite_y,
   output logic               dir_x,
   output logic               dir_y,
   output logic               frame_tick
);

   localparam logic [COORD_W-1:0] XMAX   = COORD_W'(H_ACTIVE - SPRITE_W);
   localparam logic [COORD_W-1:0] YMAX   = COORD_W'(V_ACTIVE - SPRITE_H);
   localparam logic [COORD_W-1:0] X_RST  = COORD_W'(X_INIT);
   localparam logic [COORD_W-1:0] Y_RST  = COORD_W'(Y_INIT);
   localparam logic               VS_IDLE = VSYNC_ACT_LOW;   // inactive vsync level

   state_e             state_q;
   logic [COORD_W-1:0] x_q, y_q;
   logic               dx_q, dy_q;
   logic [SPD_W-1:0]   spd_q;
   logic               tick_q;
   logic               vs_q, edge_q;
   logic               hx_q, hx_d, hy_q, hy_d;
   logic [COORD_W-1:0] nx_x, nx_y;
   logic               ndir_x, ndir_y;
   logic               lead;

   assign lead = vs_leading(vs_q, vsync, VSYNC_ACT_LOW);

   sprite_axis_step u_step_x (
      .pos     (x_q),
      .dir     (dx_q),
      .spd     (spd_q),
      .max     (XMAX),
      .new_pos (nx_x),
      .new_dir (ndir_x)
   );

   sprite_axis_step u_step_y (
      .pos     (y_q),
      .dir     (dy_q),
      .spd     (spd_q),
      .max     (YMAX),
      .new_pos (nx_y),
      .new_dir (ndir_y)
   );

   // vsync history and edge pulse; edges seen outside IDLE are dropped, not queued.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         vs_q   <= VS_IDLE;
         edge_q <= 1'b0;
      end else begin
         vs_q   <= vsync;
         edge_q <= lead && (state_q == ST_IDLE);
      end
   end

   // Sticky hit latches: cleared in STEP_Y, but a pulse in that same cycle survives.
   always_comb begin
      hx_d = hx_q | hit_x;
      hy_d = hy_q | hit_y;
      if (state_q == ST_STEP_Y) begin
         hx_d = hit_x;
         hy_d = hit_y;
      end
   end

   // Hit latch registers.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         hx_q <= 1'b0;
         hy_q <= 1'b0;
      end else begin
         hx_q <= hx_d;
         hy_q <= hy_d;
      end
   end

   // Per-frame update FSM with registered position, direction and tick outputs.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= ST_IDLE;
         x_q     <= X_RST;
         y_q     <= Y_RST;
         dx_q    <= 1'b0;
         dy_q    <= 1'b0;
         spd_q   <= '0;
         tick_q  <= 1'b0;
      end else begin
         tick_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (edge_q) state_q <= ST_LATCH;
            end
            ST_LATCH: begin
               spd_q <= speed;
               if (hx_q) dx_q <= ~dx_q;
               if (hy_q) dy_q <= ~dy_q;
               state_q <= ST_STEP_X;
            end
            ST_STEP_X: begin
               if (enable) begin
                  x_q  <= nx_x;
                  dx_q <= ndir_x;
               end
               state_q <= ST_STEP_Y;
            end
            ST_STEP_Y: begin
               if (enable) begin
                  y_q  <= nx_y;
                  dy_q <= ndir_y;
               end
               tick_q  <= 1'b1;
               state_q <= ST_DONE;
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign sprite_x   = x_q;
   assign sprite_y   = y_q;
   assign dir_x      = dx_q;
   assign dir_y      = dy_q;
   assign frame_tick = tick_q;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Bench for sprite_motion_ctrl: directed scenarios followed by random frames,
// all compared against a frame-level behavioural model.
module tb_sprite_motion_ctrl;

   localparam int XMAX = 640 - 16;
   localparam int YMAX = 480 - 16;

   logic        CLK = 1'b0;
   logic        RST;
   logic        vsync;
   logic        enable;
   logic [3:0]  speed;
   logic        hit_x, hit_y;
   logic [10:0] sprite_x, sprite_y;
   logic        dir_x, dir_y, frame_tick;

   int total = 0;
   int bad   = 0;

   // frame-level model state
   int m_x, m_y;
   bit m_dx, m_dy, m_hx, m_hy;

   sprite_motion_ctrl dut (
      .CLK        (CLK),
      .RST        (RST),
      .vsync      (vsync),
      .enable     (enable),
      .speed      (speed),
      .hit_x      (hit_x),
      .hit_y      (hit_y),
      .sprite_x   (sprite_x),
      .sprite_y   (sprite_y),
      .dir_x      (dir_x),
      .dir_y      (dir_y),
      .frame_tick (frame_tick)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      m_x = 128; m_y = 128; m_dx = 0; m_dy = 0; m_hx = 0; m_hy = 0;
   endfunction

   // Move one axis by s pixels, mirroring off the walls at 0 and mx.
   function automatic void axis(inout int p, inout bit d, input int s, input int mx);
      int n;
      n = d ? p - s : p + s;
      if (!d && n > mx) begin
         n = 2 * mx - n;
         if (n < 0) n = 0;
         d = 1;
      end else if (d && n < 0) begin
         n = -n;
         if (n > mx) n = mx;
         d = 0;
      end
      p = n;
   endfunction

   function automatic void model_frame(input int s, input bit en);
      if (m_hx) m_dx = ~m_dx;
      if (m_hy) m_dy = ~m_dy;
      m_hx = 0; m_hy = 0;
      if (en) begin
         axis(m_x, m_dx, s, XMAX);
         axis(m_y, m_dy, s, YMAX);
      end
   endfunction

   task automatic check_model(input string tag);
      check({tag, ".x"},  32'(sprite_x), m_x);
      check({tag, ".y"},  32'(sprite_y), m_y);
      check({tag, ".dx"}, 32'(dir_x), int'(m_dx));
      check({tag, ".dy"}, 32'(dir_y), int'(m_dy));
   endtask

   // One full frame; called at a negedge with the DUT idle and vsync inactive.
   task automatic run_frame(input int s, input bit en, input bit hxe, input bit hye,
                            input bit hxl, input bit hyl);
      speed  = 4'(s);
      enable = en;
      if (hxe || hye) begin
         hit_x = hxe; hit_y = hye;
         @(negedge CLK);
         hit_x = 1'b0; hit_y = 1'b0;
         m_hx |= hxe; m_hy |= hye;
      end
      vsync = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         @(posedge CLK); #1;
         check($sformatf("tick@%0d", k), 32'(frame_tick), (k == 5) ? 1 : 0);
         if (k == 4) begin hit_x = hxl; hit_y = hyl; end
         if (k == 5) begin hit_x = 1'b0; hit_y = 1'b0; end
      end
      model_frame(s, en);
      m_hx |= hxl; m_hy |= hyl;
      @(negedge CLK);
      vsync = 1'b1;
      repeat (2) @(negedge CLK);
      check_model("frame");
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RST = 1'b1; vsync = 1'b1;
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      model_reset();
      @(negedge CLK);
   endtask

   initial begin
      int fx, fy, ticks;
      RST = 1'b1; vsync = 1'b1; enable = 1'b1; speed = '0; hit_x = 1'b0; hit_y = 1'b0;
      repeat (3) @(negedge CLK);
      check("rst.x", 32'(sprite_x), 128);
      check("rst.y", 32'(sprite_y), 128);
      check("rst.dx", 32'(dir_x), 0);
      check("rst.dy", 32'(dir_y), 0);
      check("rst.tick", 32'(frame_tick), 0);
      RST = 1'b0;
      model_reset();
      @(negedge CLK);

      // straight step
      run_frame(3, 1, 0, 0, 0, 0);
      check("step.x", 32'(sprite_x), 131);
      check("step.y", 32'(sprite_y), 131);

      // right-edge bounce: 131 + 32*15 + 9 = 620, then +10 reflects to 618
      repeat (32) run_frame(15, 1, 0, 0, 0, 0);
      run_frame(9, 1, 0, 0, 0, 0);
      check("rbnc.pre_x", 32'(sprite_x), 620);
      check("rbnc.pre_dx", 32'(dir_x), 0);
      run_frame(10, 1, 0, 0, 0, 0);
      check("rbnc.x", 32'(sprite_x), 618);
      check("rbnc.dx", 32'(dir_x), 1);

      // reset while frame_tick is high
      @(negedge CLK);
      speed = 4'd5; vsync = 1'b0;
      repeat (5) @(posedge CLK);
      #1;
      check("midrst.tick_before", 32'(frame_tick), 1);
      RST = 1'b1;
      #1;
      check("midrst.x", 32'(sprite_x), 128);
      check("midrst.y", 32'(sprite_y), 128);
      check("midrst.dx", 32'(dir_x), 0);
      check("midrst.dy", 32'(dir_y), 0);
      check("midrst.tick", 32'(frame_tick), 0);
      @(negedge CLK);
      vsync = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      model_reset();
      @(negedge CLK);

      // top-edge bounce: reverse Y, 128 - 9*14 = 2
      run_frame(14, 1, 0, 1, 0, 0);
      repeat (8) run_frame(14, 1, 0, 0, 0, 0);
      check("tbnc.pre_y", 32'(sprite_y), 2);
      check("tbnc.pre_dy", 32'(dir_y), 1);
      run_frame(5, 1, 0, 0, 0, 0);
      check("tbnc.y", 32'(sprite_y), 3);
      check("tbnc.dy", 32'(dir_y), 0);
      run_frame(2, 1, 0, 0, 0, 0);
      run_frame(5, 1, 0, 1, 0, 0);
      check("tland.y", 32'(sprite_y), 0);
      check("tland.dy", 32'(dir_y), 1);
      run_frame(0, 1, 0, 0, 0, 0);
      check("spd0.y", 32'(sprite_y), 0);
      check("spd0.dy", 32'(dir_y), 1);

      // collision reversal
      do_reset();
      repeat (18) run_frame(4, 1, 0, 0, 0, 0);
      check("hit.pre_x", 32'(sprite_x), 200);
      run_frame(4, 1, 1, 0, 0, 0);
      check("hit.x", 32'(sprite_x), 196);
      check("hit.dx", 32'(dir_x), 1);
      run_frame(4, 1, 0, 0, 0, 0);
      check("hit2.x", 32'(sprite_x), 192);

      // hit in the clearing cycle carries into the next frame
      run_frame(4, 1, 0, 0, 1, 0);
      check("late.x", 32'(sprite_x), 188);
      check("late.dx", 32'(dir_x), 1);
      run_frame(4, 1, 0, 0, 0, 0);
      check("late2.x", 32'(sprite_x), 192);
      check("late2.dx", 32'(dir_x), 0);

      // freeze for 3 frames; a hit still toggles direction
      fx = m_x; fy = m_y;
      run_frame(7, 0, 0, 0, 0, 0);
      run_frame(7, 0, 1, 0, 0, 0);
      run_frame(7, 0, 0, 0, 0, 0);
      check("frz.x", 32'(sprite_x), fx);
      check("frz.y", 32'(sprite_y), fy);
      check("frz.dx", 32'(dir_x), 1);

      // second vsync edge during STEP_X is ignored
      speed = 4'd2; enable = 1'b1;
      vsync = 1'b0;
      ticks = 0;
      for (int k = 1; k <= 20; k++) begin
         @(posedge CLK); #1;
         if (frame_tick === 1'b1) ticks++;
         if (k == 2) vsync = 1'b1;
         if (k == 3) vsync = 1'b0;
      end
      check("xedge.ticks", 32'(ticks), 1);
      model_frame(2, 1);
      @(negedge CLK);
      vsync = 1'b1;
      repeat (2) @(negedge CLK);
      check_model("xedge");

      // random frames
      for (int f = 0; f < 60; f++) begin
         run_frame(int'($urandom_range(0, 15)), ($urandom_range(0, 7) != 0),
                   ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
                   ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
